cia_multiword_seq_adder: RTL and testbench
==========================================

Name: cia_multiword_seq_adder

Overview:
Sequential wide-operand adder that feeds the carry_increment_adder one WIDTH-bit slice per cycle, LSB slice first. Captures two (WIDTH*BEATS)-bit operands through a valid/ready handshake and contains one carry_increment_adder #(WIDTH) instance. Registers each slice sum and carries carry_out into the next beat. Presents the full sum and final carry with a valid/ready output handshake. Sits between the operand source and the result consumer in the datapath.

Parameters:
WIDTH, 8, slice width; passed to the internal carry_increment_adder.
BEATS, 4, number of slices per operand (>=1); total operand width N = WIDTH*BEATS.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand set a/b/carry_in is valid
in_ready  output  1  block can accept operands; high only in IDLE
a  input  N  operand A
b  input  N  operand B
carry_in  input  1  carry into slice 0
out_valid  output  1  sum/carry_out valid; high only in DONE
out_ready  input  1  consumer accepts result
sum  output  N  registered result
carry_out  output  1  registered carry out of the top slice
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE, beat counter=0, carry register=0, sum=0, carry_out=0, out_valid=0. The internal operand registers are don't-care. Reset overrides every other input, including reset in mid-RUN or in DONE. In that case the in-flight operation is discarded and out_valid never asserts for it.
- in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state!=IDLE). All three decode from registered state only, with no combinational input-to-output path.
- IDLE: when in_valid=1 on an edge, capture a, b, carry register<=carry_in, beat<=0, clear sum to 0, and go to RUN. When in_valid=0, stay in IDLE.
- RUN: the adder inputs are a[beat*WIDTH +: WIDTH], b[same], and the carry register. On each edge:
  - sum[beat*WIDTH +: WIDTH] <= adder sum
  - carry register <= adder carry_out
  - if beat==BEATS-1: carry_out <= adder carry_out, go to DONE; otherwise beat <= beat+1.
  - in_valid is ignored.
- DONE: sum and carry_out are held stable. When out_ready=1 on an edge, go to IDLE. Otherwise stay, with outputs unchanged for as long as back-pressure lasts. in_valid is ignored.
- Latency: accept edge E. out_valid is high after edge E+BEATS, so exactly BEATS cycles in RUN. The minimum cycle-to-cycle throughput is one operation per BEATS+2 edges: accept, BEATS run edges, and the handshake edge.
- Arithmetic: {carry_out, sum} = a + b + carry_in, modulo 2^(N+1). Wrap-around shows only through carry_out=1.
- The beat counter is clog2(BEATS) bits, minimum 1 bit. BEATS=1 goes IDLE->RUN->DONE with a single run edge.
- Simultaneous in_valid and out_ready in DONE: the result handshake completes and the new operands are not captured. The source must hold in_valid until it sees in_ready=1.
- sum holds its last value in IDLE until the next accept clears it.

Test Plan:
1. WIDTH=8, BEATS=4; a=0x0000001B, b=0x00000035, cin=0, out_ready=1 -> out_valid exactly 4 cycles after accept; sum=0x00000050, carry_out=0; in_ready=0 during RUN/DONE.
2. a=0xFFFFFFFF, b=0x00000001, cin=1 -> sum=0x00000001, carry_out=1 (full-width wrap). Intermediate slice carries of 1 propagate on every beat.
3. a=0x00FFFFFF, b=0x00000001, cin=0 -> sum=0x01000000, carry_out=0. Checks carry crossing beat boundaries 0->1->2->3.
4. Back-pressure: case 1 with out_ready=0 for 5 cycles in DONE, and in_valid pulsed with a=0x11111111 -> sum/carry_out stable, in_ready=0, pulse ignored. Raising out_ready -> IDLE on the next edge, in_ready=1.
5. Reset mid-operation: rst=1 for one edge after beat 1 of case 2 -> out_valid stays 0, sum=0, carry_out=0, in_ready=1 on the next cycle. A following case 1 completes correctly.
6. BEATS=1, WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, carry_out=1, out_valid 1 cycle after accept.

Source files
------------

// File: rtl/cia_multiword_seq_adder.sv
// Multi-beat wide adder: streams WIDTH-bit slices of two wide operands through a
// carry-increment adder, LSB slice first, with valid/ready handshakes on both sides.

module carry_increment_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int BLK  = 4;
    localparam int NBLK = (WIDTH + BLK - 1) / BLK;

    logic [NBLK:0] c;
    assign c[0] = carry_in;

    // Each block adds with carry 0, then increments by the incoming carry; the block
    // carry is its own carry or an all-ones partial sum propagating the incoming one.
    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        localparam int LO = i * BLK;
        localparam int BW = (WIDTH - LO < BLK) ? (WIDTH - LO) : BLK;
        logic [BW:0] raw;
        assign raw          = {1'b0, a[LO +: BW]} + {1'b0, b[LO +: BW]};
        assign sum[LO +: BW] = raw[BW-1:0] + BW'(c[i]);
        assign c[i+1]       = raw[BW] | (c[i] & (&raw[BW-1:0]));
    end

    assign carry_out = c[NBLK];
endmodule

module cia_multiword_seq_adder #(
    parameter int WIDTH = 8,
    parameter int BEATS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*BEATS-1:0] a,
    input  logic [WIDTH*BEATS-1:0] b,
    input  logic                   carry_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*BEATS-1:0] sum,
    output logic                   carry_out,
    output logic                   busy
);
    localparam int N  = WIDTH * BEATS;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    beat;
    logic             carry_reg;
    logic [N-1:0]     a_reg;
    logic [N-1:0]     b_reg;
    logic [WIDTH-1:0] a_slice;
    logic [WIDTH-1:0] b_slice;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (beat == CW'(i)) begin
                a_slice = a_reg[i*WIDTH +: WIDTH];
                b_slice = b_reg[i*WIDTH +: WIDTH];
            end
        end
    end

    carry_increment_adder #(.WIDTH(WIDTH)) u_add (
        .a         (a_slice),
        .b         (b_slice),
        .carry_in  (carry_reg),
        .sum       (add_sum),
        .carry_out (add_cout)
    );

    // Operand registers are reset only for determinism; their value in IDLE is unused.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= '0;
            carry_reg <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= carry_in;
                        beat      <= '0;
                        sum       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < BEATS; i++) begin
                        if (beat == CW'(i)) sum[i*WIDTH +: WIDTH] <= add_sum;
                    end
                    carry_reg <= add_cout;
                    if (beat == CW'(BEATS - 1)) begin
                        carry_out <= add_cout;
                        state     <= DONE;
                    end else begin
                        beat <= beat + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cia_multiword_seq_adder.sv
// Randomized self-checking bench for cia_multiword_seq_adder (BEATS=4 and BEATS=1 instances)
// against a plain-arithmetic reference sum.

module tb_cia_multiword_seq_adder;
    localparam int W  = 8;
    localparam int BT = 4;
    localparam int N  = W * BT;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [N-1:0] a, b, sum;
    logic         carry_in, carry_out;

    logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [W-1:0] a1, b1, sum1;
    logic         carry_in1, carry_out1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cia_multiword_seq_adder #(.WIDTH(W), .BEATS(BT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(carry_in), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .carry_out(carry_out), .busy(busy)
    );

    cia_multiword_seq_adder #(.WIDTH(W), .BEATS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .carry_in(carry_in1), .out_valid(out_valid1),
        .out_ready(out_ready1), .sum(sum1), .carry_out(carry_out1), .busy(busy1)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One full operation on the 4-beat instance: accept, latency, optional back-pressure
    // with an ignored in_valid pulse, then the result handshake.
    task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv,
                                 input logic cv, input int bp, input logic pulse);
        logic [N:0] exp;
        int         waited;
        exp    = {1'b0, av} + {1'b0, bv} + {{N{1'b0}}, cv};
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        a = av; b = bv; carry_in = cv; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        checkOutput("sum_cleared", 64'(sum), 64'd0);
        for (int k = 0; k < BT; k++) begin
            checkOutput("out_valid_run", 64'(out_valid), 64'd0);
            checkOutput("in_ready_run", 64'(in_ready), 64'd0);
            checkOutput("busy_run", 64'(busy), 64'd1);
            @(negedge clk);
        end
        checkOutput("out_valid_done", 64'(out_valid), 64'd1);
        checkOutput("sum", 64'(sum), 64'(exp[N-1:0]));
        checkOutput("carry_out", 64'(carry_out), 64'(exp[N]));
        for (int k = 0; k < bp; k++) begin
            in_valid = pulse && (k == 1);
            a = 32'h11111111;
            @(negedge clk);
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_sum", 64'(sum), 64'(exp[N-1:0]));
            checkOutput("hold_cout", 64'(carry_out), 64'(exp[N]));
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
        end
        // in_valid stays high through the handshake edge: it must not be captured.
        in_valid  = pulse;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("idle_in_ready", 64'(in_ready), 64'd1);
        checkOutput("idle_busy", 64'(busy), 64'd0);
        checkOutput("idle_sum_held", 64'(sum), 64'(exp[N-1:0]));
    endtask

    task automatic runSingle(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        logic [W:0] exp;
        exp = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
        a1 = av; b1 = bv; carry_in1 = cv; in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        checkOutput("b1_out_valid_run", 64'(out_valid1), 64'd0);
        checkOutput("b1_in_ready_run", 64'(in_ready1), 64'd0);
        @(negedge clk);
        checkOutput("b1_out_valid", 64'(out_valid1), 64'd1);
        checkOutput("b1_sum", 64'(sum1), 64'(exp[W-1:0]));
        checkOutput("b1_cout", 64'(carry_out1), 64'(exp[W]));
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        checkOutput("b1_idle", 64'(in_ready1), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; carry_in = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; carry_in1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_sum", 64'(sum), 64'd0);
        checkOutput("rst_cout", 64'(carry_out), 64'd0);

        applyStimulus(32'h0000001B, 32'h00000035, 1'b0, 0, 1'b0);
        applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b1, 0, 1'b0);
        applyStimulus(32'h00FFFFFF, 32'h00000001, 1'b0, 0, 1'b0);
        applyStimulus(32'h0000001B, 32'h00000035, 1'b0, 5, 1'b1);

        // Reset after the second run edge of a wrap-around operation.
        a = 32'hFFFFFFFF; b = 32'h00000001; carry_in = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_sum", 64'(sum), 64'd0);
        checkOutput("midrst_cout", 64'(carry_out), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (BT + 2) begin
            @(negedge clk);
            checkOutput("midrst_no_valid", 64'(out_valid), 64'd0);
        end
        applyStimulus(32'h0000001B, 32'h00000035, 1'b0, 0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            applyStimulus(N'($urandom), N'($urandom), 1'($urandom_range(1)),
                          int'($urandom_range(3)), 1'($urandom_range(1)));
        end
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1, 1'b0);

        runSingle(8'hFF, 8'h01, 1'b0);
        for (int t = 0; t < 6; t++) begin
            runSingle(W'($urandom), W'($urandom), 1'($urandom_range(1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
